// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_pkg
// Description : Shared constants for the row-oriented pixel stream receiver:
//               pixel width, error flag bit positions and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

    localparam int PIX_W = 24;

    // Bit positions inside the sticky error flag vector
    localparam int ERR_SHORT   = 0;   // H_Jump before the row was full
    localparam int ERR_LONG    = 1;   // extra pixel after the row was full
    localparam int ERR_RESTART = 2;   // Start seen while a frame was running
    localparam int ERR_BOTH    = 3;   // H_Valid and H_Jump in the same cycle
    localparam int ERR_W       = 4;

    // Receiver states
    localparam logic [1:0] ST_IDLE  = 2'd0;   // waiting for Start
    localparam logic [1:0] ST_PIXEL = 2'd1;   // accepting row pixels
    localparam logic [1:0] ST_EOL   = 2'd2;   // row full, awaiting H_Jump

endpackage
`default_nettype wire

// File: rtl/pixel_stream_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_receiver_if
// Description : Bundles the pixel stream input and the frame-buffer write /
//               status outputs of the receiver.
//               master : stream source (drives Start/H_Valid/H_Jump/Bmp_Data)
//               slave  : receiver     (drives Wr_*, Busy, Frame_Done, Err_Flags)
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_stream_receiver_if
    import pixel_stream_pkg::*;
#(
    parameter int W  = 256,
    parameter int H  = 256,
    parameter int AW = $clog2(W * H)
);
    logic              Start_in;
    logic              H_Valid_in;
    logic              H_Jump_in;
    logic [PIX_W-1:0]  Bmp_Data;
    logic              Wr_En;
    logic [AW-1:0]     Wr_Addr;
    logic [PIX_W-1:0]  Wr_Data;
    logic              Busy;
    logic              Frame_Done;
    logic [ERR_W-1:0]  Err_Flags;

    modport master (
        output Start_in, H_Valid_in, H_Jump_in, Bmp_Data,
        input  Wr_En, Wr_Addr, Wr_Data, Busy, Frame_Done, Err_Flags
    );

    modport slave (
        input  Start_in, H_Valid_in, H_Jump_in, Bmp_Data,
        output Wr_En, Wr_Addr, Wr_Data, Busy, Frame_Done, Err_Flags
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_receiver
// Description : Receives a row-oriented pixel stream (Start with first pixel,
//               W valid pixels per row, one H_Jump per row) and converts it
//               into linear frame-buffer writes at row*W+col. Pulses
//               Frame_Done after the last row's H_Jump, and aborts to IDLE on
//               framing violations while recording sticky error flags.
// Ports       : Clk_in  - clock, all logic on rising edge
//               Rst_in  - synchronous active-high reset
//               bus     - stream inputs and write/status outputs (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_receiver
    import pixel_stream_pkg::*;
#(
    parameter int W  = 256,
    parameter int H  = 256,
    parameter int AW = $clog2(W * H)
) (
    input  logic                     Clk_in,
    input  logic                     Rst_in,
    pixel_stream_receiver_if.slave   bus
);

    localparam int COL_W = $clog2(W);
    localparam int ROW_W = $clog2(H) + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [AW-1:0]    addr;       // running write address, replaces row*W+col

    logic             frame_start;
    logic             pix_write;
    logic             row_jump;
    logic             last_jump;
    logic [ERR_W-1:0] err_set;

    wire valid = bus.H_Valid_in;
    wire jump  = bus.H_Jump_in;
    wire start = bus.Start_in & bus.H_Valid_in;

    // Event decode. Valid+Jump outranks everything else once a frame is
    // running, and a mid-frame Start outranks the normal PIXEL/EOL rules.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        pix_write   = 1'b0;
        row_jump    = 1'b0;
        last_jump   = 1'b0;
        err_set     = '0;
        if (state == ST_IDLE) begin
            if (start) begin
                frame_start = 1'b1;
                next_state  = ST_PIXEL;
            end
        end else if (valid && jump) begin
            err_set[ERR_BOTH] = 1'b1;
            next_state        = ST_IDLE;
        end else if (start) begin
            err_set[ERR_RESTART] = 1'b1;
            frame_start          = 1'b1;
            next_state           = ST_PIXEL;
        end else if (state == ST_PIXEL) begin
            if (valid) begin
                pix_write = 1'b1;
                if (col == COL_LAST) begin
                    next_state = ST_EOL;
                end
            end else if (jump) begin
                err_set[ERR_SHORT] = 1'b1;
                next_state         = ST_IDLE;
            end
        end else begin
            if (jump) begin
                row_jump = 1'b1;
                if (row == ROW_LAST) begin
                    last_jump  = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_PIXEL;
                end
            end else if (valid) begin
                err_set[ERR_LONG] = 1'b1;
                next_state        = ST_IDLE;
            end
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            state          <= ST_IDLE;
            col            <= '0;
            row            <= '0;
            addr           <= '0;
            bus.Wr_En      <= 1'b0;
            bus.Wr_Addr    <= '0;
            bus.Wr_Data    <= '0;
            bus.Busy       <= 1'b0;
            bus.Frame_Done <= 1'b0;
            bus.Err_Flags  <= '0;
        end else begin
            state          <= next_state;
            bus.Busy       <= (next_state != ST_IDLE);
            bus.Frame_Done <= last_jump;
            bus.Wr_En      <= frame_start | pix_write;

            // A Start from IDLE begins a clean frame; a resync keeps history.
            if (frame_start && (state == ST_IDLE)) begin
                bus.Err_Flags <= '0;
            end else begin
                bus.Err_Flags <= bus.Err_Flags | err_set;
            end

            if (frame_start) begin
                bus.Wr_Addr <= '0;
                bus.Wr_Data <= bus.Bmp_Data;
                addr        <= AW'(1);
                col         <= COL_W'(1);
                row         <= '0;
            end else if (pix_write) begin
                bus.Wr_Addr <= addr;
                bus.Wr_Data <= bus.Bmp_Data;
                addr        <= addr + AW'(1);
                col         <= col + COL_W'(1);
            end else if (row_jump) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_receiver
// Description : Self-checking bench for pixel_stream_receiver (W=4, H=2).
//               A pixel-count based reference model predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_receiver;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = $clog2(W * H);
    localparam int VW = 1 + AW + 24 + 1 + 1 + 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pixel_stream_receiver_if #(.W(W), .H(H), .AW(AW)) bus ();

    pixel_stream_receiver #(.W(W), .H(H), .AW(AW)) dut (
        .Clk_in (clk),
        .Rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (frame = count of pixels and jumps)
    bit          m_active;
    int          m_pix;
    int          m_jumps;
    logic [3:0]  m_flags;
    logic        m_wr;
    logic        m_done;
    logic [AW-1:0] m_addr;
    logic [23:0] m_data;

    task automatic m_start(input logic [23:0] d);
        m_wr = 1'b1; m_addr = '0; m_data = d;
        m_pix = 1; m_jumps = 0; m_active = 1'b1;
    endtask

    task automatic model(input logic r, s, v, j, input logic [23:0] d);
        m_wr = 1'b0; m_done = 1'b0;
        if (r) begin
            m_active = 1'b0; m_pix = 0; m_jumps = 0; m_flags = '0;
            m_addr = '0; m_data = '0;
        end else if (!m_active) begin
            if (s && v) begin m_flags = '0; m_start(d); end
        end else if (v && j) begin
            m_flags[3] = 1'b1; m_active = 1'b0;
        end else if (s && v) begin
            m_flags[2] = 1'b1; m_start(d);
        end else if (m_pix < (m_jumps + 1) * W) begin
            if (v) begin
                m_wr = 1'b1; m_addr = AW'(m_pix); m_data = d; m_pix++;
            end else if (j) begin
                m_flags[0] = 1'b1; m_active = 1'b0;
            end
        end else begin
            if (j) begin
                m_jumps++;
                if (m_jumps == H) begin m_done = 1'b1; m_active = 1'b0; end
            end else if (v) begin
                m_flags[1] = 1'b1; m_active = 1'b0;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_wr, m_wr ? m_addr : {AW{1'b0}}, m_wr ? m_data : 24'h0,
                m_active, m_done, m_flags};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.Wr_En, bus.Wr_En ? bus.Wr_Addr : {AW{1'b0}},
                bus.Wr_En ? bus.Wr_Data : 24'h0, bus.Busy, bus.Frame_Done,
                bus.Err_Flags};
    endfunction

    function automatic logic [VW-1:0] raw_vec();
        return {bus.Wr_En, bus.Wr_Addr, bus.Wr_Data, bus.Busy,
                bus.Frame_Done, bus.Err_Flags};
    endfunction

    // ---------------- stimulus
    typedef struct { logic s; logic v; logic j; logic [23:0] d; } stim_t;
    stim_t q[$];

    task automatic step(input logic r, s, v, j, input logic [23:0] d);
        rst = r; bus.Start_in = s; bus.H_Valid_in = v;
        bus.H_Jump_in = j; bus.Bmp_Data = d;
        @(posedge clk);
        model(r, s, v, j, d);
        #1;
    endtask

    task automatic push(input logic s, v, j, input logic [23:0] d);
        stim_t e;
        e.s = s; e.v = v; e.j = j; e.d = d;
        q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'b0, 24'($urandom));
    endtask

    // Conforming frame; optional idle gap before pixel (gr,gc).
    task automatic push_frame(input bit seq, input int gr, gc, gn);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == gr && c == gc) push_idle(gn);
                push(r == 0 && c == 0, 1'b1, 1'b0,
                     seq ? 24'(r * W + c + 1) : 24'($urandom));
            end
            push(1'b0, 1'b0, 1'b1, 24'h0);
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 24'hABCDEF);
        total++;
        if (raw_vec() !== '0) begin
            bad++; $display("FAIL reset got=%h want=0", raw_vec());
        end
    endtask

    task automatic test_conforming();
        int dones = 0;
        q.delete();
        push_frame(1'b1, -1, -1, 0);
        push_idle(2);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            if (bus.Frame_Done === 1'b1) dones++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL conforming cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (dones !== 1) begin
            bad++; $display("FAIL conforming_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_idle_gaps();
        q.delete();
        push_frame(1'b1, 1, 2, 3);
        push_idle(1);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL idle_gaps cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_short_row();
        q.delete();
        push(1'b1, 1'b1, 1'b0, 24'h11);
        push(1'b0, 1'b1, 1'b0, 24'h12);
        push(1'b0, 1'b1, 1'b0, 24'h13);
        push(1'b0, 1'b0, 1'b1, 24'h0);       // jump after 3 pixels
        push_idle(2);
        push_frame(1'b0, -1, -1, 0);          // new Start clears flags
        push_idle(1);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL short_row cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_long_row();
        q.delete();
        push(1'b1, 1'b1, 1'b0, 24'h21);
        for (int c = 1; c < W; c++) push(1'b0, 1'b1, 1'b0, 24'(32'h21 + c));
        push(1'b0, 1'b1, 1'b0, 24'h99);       // extra pixel instead of jump
        push(1'b0, 1'b1, 1'b0, 24'h98);       // valid-only in IDLE: ignored
        push(1'b0, 1'b0, 1'b1, 24'h0);        // jump-only in IDLE: ignored
        push(1'b0, 1'b1, 1'b1, 24'h0);        // both in IDLE: ignored
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL long_row cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        q.delete();
        push(1'b1, 1'b1, 1'b0, 24'h31);
        for (int c = 1; c < W; c++) push(1'b0, 1'b1, 1'b0, 24'(32'h31 + c));
        push(1'b0, 1'b0, 1'b1, 24'h0);
        push(1'b0, 1'b1, 1'b0, 24'h41);
        push(1'b0, 1'b1, 1'b0, 24'h42);
        push_frame(1'b0, -1, -1, 0);          // Start lands at row 1 col 2
        push_idle(1);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL restart cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (bus.Err_Flags !== 4'b0100) begin
            bad++; $display("FAIL restart_flag got=%b want=0100", bus.Err_Flags);
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        push_frame(1'b0, -1, -1, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        void'(q.pop_back());
        void'(q.pop_back());                  // stop at row 1 col 1
        push(1'b1, 1'b1, 1'b0, 24'h55);       // mid-frame restart sets a flag
        push(1'b0, 1'b1, 1'b0, 24'h56);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 24'h77);
        total++;
        if (raw_vec() !== '0) begin
            bad++; $display("FAIL reset_mid got=%h want=0", raw_vec());
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_valid cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random_frames();
        q.delete();
        for (int f = 0; f < 6; f++) begin
            push_frame(1'b0, $urandom_range(0, H - 1), $urandom_range(0, W - 1),
                       $urandom_range(0, 3));
            push_idle($urandom_range(0, 2));
        end
        for (int i = 0; i < q.size(); i++) begin
            step(1'b0, q[i].s, q[i].v, q[i].j, q[i].d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_frames cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random_chaos();
        logic s, v, j;
        for (int i = 0; i < 500; i++) begin
            s = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 9) < 7);
            j = ($urandom_range(0, 5) == 0);
            step(1'b0, s, v, j, 24'($urandom));
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_chaos cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.Start_in = 1'b0; bus.H_Valid_in = 1'b0;
        bus.H_Jump_in = 1'b0; bus.Bmp_Data = '0;
        m_active = 1'b0; m_pix = 0; m_jumps = 0; m_flags = '0;
        m_wr = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
        test_reset();
        test_conforming();
        test_idle_gaps();
        test_short_row();
        test_long_row();
        test_restart();
        test_reset_mid();
        test_random_frames();
        test_random_chaos();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
